// File: rtl/bmem_responder.sv
// bmem_responder: burst-memory backing model for the cpu_top bmem_* port.
// Optional protocol checker is enabled by defining BMEM_RESP_PROTOCOL_CHECK_EN.
module bmem_responder #(
   parameter int MEM_LINES = 1024,
   parameter int RQ_DEPTH  = 4,
   parameter int LATENCY   = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] bmem_addr,
   input  logic        bmem_read,
   input  logic        bmem_write,
   input  logic [63:0] bmem_wdata,
   output logic        bmem_ready,
   output logic [31:0] bmem_raddr,
   output logic [63:0] bmem_rdata,
   output logic        bmem_rvalid,
   output logic        bmem_err
);

   localparam int IW = $clog2(MEM_LINES);
   localparam int PW = (RQ_DEPTH > 1) ? $clog2(RQ_DEPTH) : 1;
   localparam int CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;
   // One cycle of latency is spent in the stream FSM register.
   localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 2);
   localparam logic [PW:0]   DEPTH_C  = (PW+1)'(RQ_DEPTH);
   localparam logic [PW:0]   ONE_C    = (PW+1)'(1);

   typedef enum logic [2:0] {
      R_IDLE = 3'b000,
      R_B0   = 3'b100,
      R_B1   = 3'b101,
      R_B2   = 3'b110,
      R_B3   = 3'b111
   } rstate_t;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_1    = 2'd1,
      W_2    = 2'd2,
      W_3    = 2'd3
   } wstate_t;

   logic [63:0]   mem    [MEM_LINES][4];
   logic [31:0]   q_addr [RQ_DEPTH];
   logic [255:0]  q_data [RQ_DEPTH];
   logic [CW-1:0] q_cnt  [RQ_DEPTH];

   logic [PW-1:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
   logic [PW:0]   count;
   rstate_t       rs, rs_nxt;
   wstate_t       ws, ws_nxt;
   logic [IW-1:0] line;
   logic [255:0]  snap;
   logic [1:0]    w_idx;
   logic [1:0]    beat;
   logic          rd_acc, wr_beat, pop;
   logic          head_ok, next_ok;

   assign line = bmem_addr[5+IW-1:5];
   assign snap = {mem[line][3], mem[line][2],
                  mem[line][1], mem[line][0]};

   assign wr_nxt = (wr_ptr == PW'(RQ_DEPTH-1)) ? '0 : wr_ptr + 1'b1;
   assign rd_nxt = (rd_ptr == PW'(RQ_DEPTH-1)) ? '0 : rd_ptr + 1'b1;

   assign bmem_ready = (count < DEPTH_C) & ~rst;

   assign rd_acc = bmem_read & bmem_ready
                 & (ws == W_IDLE) & ~bmem_write;

   // ---------------- write FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) ws <= W_IDLE;
      else     ws <= ws_nxt;
   end

   always_comb begin
      ws_nxt = ws;
      case (ws)
         W_IDLE:  if (bmem_write & bmem_ready) ws_nxt = W_1;
         W_1:     ws_nxt = bmem_write ? W_2 : W_IDLE;
         W_2:     ws_nxt = bmem_write ? W_3 : W_IDLE;
         W_3:     ws_nxt = W_IDLE;
         default: ws_nxt = W_IDLE;
      endcase
   end

   always_comb begin
      w_idx   = ws;
      wr_beat = 1'b0;
      if (ws == W_IDLE) wr_beat = bmem_write & bmem_ready;
      else              wr_beat = bmem_write & ~rst;
   end

   always_ff @(posedge clk) begin
      if (wr_beat) mem[line][w_idx] <= bmem_wdata;
   end

   // ---------------- read queue ----------------
   always_ff @(posedge clk) begin
      if (rd_acc) begin
         q_addr[wr_ptr] <= bmem_addr;
         q_data[wr_ptr] <= snap;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < RQ_DEPTH; i++) q_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < RQ_DEPTH; i++) begin
            if (rd_acc && wr_ptr == PW'(i))
               q_cnt[i] <= CNT_INIT;
            else if (q_cnt[i] != '0)
               q_cnt[i] <= q_cnt[i] - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (rd_acc) wr_ptr <= wr_nxt;
         if (pop)    rd_ptr <= rd_nxt;
         case ({rd_acc, pop})
            2'b10:   count <= count + ONE_C;
            2'b01:   count <= count - ONE_C;
            default: count <= count;
         endcase
      end
   end

   // ---------------- read stream FSM ----------------
   // In BEAT3 the head is still the draining burst, so the follower is next.
   assign head_ok = (count != '0) && (q_cnt[rd_ptr] == '0);
   assign next_ok = (count > ONE_C) && (q_cnt[rd_nxt] == '0);

   always_ff @(posedge clk) begin
      if (rst) rs <= R_IDLE;
      else     rs <= rs_nxt;
   end

   always_comb begin
      rs_nxt = rs;
      case (rs)
         R_IDLE:  if (head_ok) rs_nxt = R_B0;
         R_B0:    rs_nxt = R_B1;
         R_B1:    rs_nxt = R_B2;
         R_B2:    rs_nxt = R_B3;
         R_B3:    rs_nxt = next_ok ? R_B0 : R_IDLE;
         default: rs_nxt = R_IDLE;
      endcase
   end

   always_comb begin
      beat        = rs[1:0];
      bmem_rvalid = 1'b0;
      bmem_raddr  = '0;
      bmem_rdata  = '0;
      pop         = (rs == R_B3);
      if (rs[2]) begin
         bmem_rvalid = 1'b1;
         bmem_raddr  = q_addr[rd_ptr];
         bmem_rdata  = q_data[rd_ptr][{beat, 6'd0} +: 64];
      end
   end

`ifdef BMEM_RESP_PROTOCOL_CHECK_EN
   logic        err_q;
   logic        viol;
   logic [31:0] w_addr_q;

   always_comb begin
      viol = 1'b0;
      if ((bmem_read | bmem_write) && bmem_addr[4:0] != 5'd0)
         viol = 1'b1;
      if (bmem_read & bmem_write)
         viol = 1'b1;
      if (ws != W_IDLE) begin
         if (bmem_read) viol = 1'b1;
         if (!bmem_write || bmem_addr != w_addr_q) viol = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q    <= 1'b0;
         w_addr_q <= '0;
      end else begin
         if (wr_beat && ws == W_IDLE) w_addr_q <= bmem_addr;
         if (viol) begin
            err_q <= 1'b1;
`ifndef SYNTHESIS
            $error("bmem_responder: protocol violation addr=%h", bmem_addr);
`endif
         end
      end
   end

   assign bmem_err = err_q;
`else
   assign bmem_err = 1'b0;
`endif

endmodule

// File: tb/tb_bmem_responder.sv
// tb_bmem_responder: table vectors plus corner sequences for bmem_responder.
// Read beats are matched in order against expectations queued at accept.
module tb_bmem_responder;

   typedef struct {
      logic [31:0] a;
      logic [63:0] d;
   } beat_t;

   typedef struct {
      logic [31:0]  waddr;
      logic [31:0]  raddr;
      logic [255:0] data;
   } vec_t;

`ifdef BMEM_RESP_PROTOCOL_CHECK_EN
   localparam logic ERR_EXP = 1'b1;
`else
   localparam logic ERR_EXP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] bmem_addr;
   logic        bmem_read;
   logic        bmem_write;
   logic [63:0] bmem_wdata;
   logic        bmem_ready;
   logic [31:0] bmem_raddr;
   logic [63:0] bmem_rdata;
   logic        bmem_rvalid;
   logic        bmem_err;

   beat_t sbq[$];
   int    beat_cyc[$];
   beat_t mon_e;
   int    checks = 0;
   int    errors = 0;
   int    cyc = 0;
   bit    mon_en = 1'b0;

   bmem_responder dut (
      .clk        (clk),
      .rst        (rst),
      .bmem_addr  (bmem_addr),
      .bmem_read  (bmem_read),
      .bmem_write (bmem_write),
      .bmem_wdata (bmem_wdata),
      .bmem_ready (bmem_ready),
      .bmem_raddr (bmem_raddr),
      .bmem_rdata (bmem_rdata),
      .bmem_rvalid(bmem_rvalid),
      .bmem_err   (bmem_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en && bmem_rvalid === 1'b1) begin
         beat_cyc.push_back(cyc);
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL stray_beat: got raddr %h want no beat (cycle %0d)",
                     bmem_raddr, cyc);
         end else begin
            mon_e = sbq.pop_front();
            chk("raddr", {32'h0, bmem_raddr}, {32'h0, mon_e.a});
            chk("rdata", bmem_rdata, mon_e.d);
         end
      end
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_ready(input string name);
      int n = 0;
      while (bmem_ready !== 1'b1 && n < 200) begin
         step();
         n++;
      end
      if (n >= 200) begin
         checks++;
         errors++;
         $display("FAIL %s: got ready=%b want 1 within 200 cycles",
                  name, bmem_ready);
      end
   endtask

   task automatic do_write(input logic [31:0] a, input logic [255:0] d,
                           input logic also_rd);
      bmem_addr  = a;
      bmem_write = 1'b1;
      bmem_read  = also_rd;
      wait_ready("wr_ready");
      for (int i = 0; i < 4; i++) begin
         bmem_wdata = d[64*i +: 64];
         step();
      end
      bmem_write = 1'b0;
      bmem_read  = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] a, input logic [255:0] d,
                          output int t);
      bmem_addr = a;
      bmem_read = 1'b1;
      wait_ready("rd_ready");
      t = cyc;
      for (int i = 0; i < 4; i++)
         sbq.push_back('{a, d[64*i +: 64]});
      step();
      bmem_read = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sbq.size() != 0 && n < 300) begin
         step();
         n++;
      end
      if (sbq.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d beats missing want 0", sbq.size());
         sbq.delete();
      end
      step(2);
   endtask

   initial begin
      vec_t         vt[6];
      logic [255:0] bdat, cdat, pexp;
      int           t, t2;

      vt[0] = '{32'h0000_0100, 32'h0000_0100,
                {64'hA3A3_0000_0000_0103, 64'hA2A2_0000_0000_0102,
                 64'hA1A1_0000_0000_0101, 64'hA0A0_0000_0000_0100}};
      vt[1] = '{32'h0000_0000, 32'h0000_8000,
                {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888,
                 64'h9999_AAAA_BBBB_CCCC, 64'hDDDD_EEEE_FFFF_0000}};
      vt[2] = '{32'h0000_0200, 32'h0000_0200,
                {64'h0200_0000_0000_0003, 64'h0200_0000_0000_0002,
                 64'h0200_0000_0000_0001, 64'h0200_0000_0000_0000}};
      vt[3] = '{32'h0000_7FE0, 32'h0000_7FE0,
                {64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000,
                 64'h8000_0000_0000_0001, 64'h7FFF_FFFF_FFFF_FFFE}};
      vt[4] = '{32'h0000_0040, 32'hFFFF_8040,
                {64'h4040_0000_0000_0003, 64'h4040_0000_0000_0002,
                 64'h4040_0000_0000_0001, 64'h4040_0000_0000_0000}};
      vt[5] = '{32'h0000_01E0, 32'h0000_01E0,
                {64'h1E1E_DEAD_BEEF_0003, 64'h1E1E_DEAD_BEEF_0002,
                 64'h1E1E_DEAD_BEEF_0001, 64'h1E1E_DEAD_BEEF_0000}};
      bdat = {64'hB3B3_B3B3_B3B3_B3B3, 64'hB2B2_B2B2_B2B2_B2B2,
              64'hB1B1_B1B1_B1B1_B1B1, 64'hB0B0_B0B0_B0B0_B0B0};
      cdat = {64'hC3C3_0000_0000_C3C3, 64'hC2C2_0000_0000_C2C2,
              64'hC1C1_0000_0000_C1C1, 64'hC0C0_0000_0000_C0C0};

      rst        = 1'b1;
      bmem_addr  = '0;
      bmem_read  = 1'b0;
      bmem_write = 1'b0;
      bmem_wdata = '0;

      // reset state
      step(3);
      chk("rst_ready", {63'h0, bmem_ready}, 64'h0);
      chk("rst_rvalid", {63'h0, bmem_rvalid}, 64'h0);
      chk("rst_raddr", {32'h0, bmem_raddr}, 64'h0);
      chk("rst_rdata", bmem_rdata, 64'h0);
      chk("rst_err", {63'h0, bmem_err}, 64'h0);
      rst = 1'b0;
      #1;
      chk("ready_after_rst", {63'h0, bmem_ready}, 64'h1);
      mon_en = 1'b1;
      step();

      // table vectors: write then read back, latency T+10..T+13
      for (int i = 0; i < 6; i++) begin
         beat_cyc.delete();
         do_write(vt[i].waddr, vt[i].data, 1'b0);
         do_read(vt[i].raddr, vt[i].data, t);
         drain();
         chk("lat_first", 64'(beat_cyc[0]), 64'(t + 10));
         chk("lat_last", 64'(beat_cyc[3]), 64'(t + 13));
      end

      // four back-to-back reads fill the queue
      beat_cyc.delete();
      do_read(32'h0000_0100, vt[0].data, t);
      do_read(32'h0000_0000, vt[1].data, t2);
      do_read(32'h0000_0200, vt[2].data, t2);
      do_read(32'h0000_7FE0, vt[3].data, t2);
      chk("b2b_accept", 64'(t2), 64'(t + 3));
      for (int c = 4; c <= 14; c++) begin
         chk("b2b_ready", {63'h0, bmem_ready}, {63'h0, (c >= 14)});
         step();
      end
      drain();
      chk("b2b_beats", 64'(beat_cyc.size()), 64'd16);
      for (int k = 0; k < 16; k++)
         chk("b2b_contig", 64'(beat_cyc[k]), 64'(t + 10 + k));

      // read snapshot taken before an overlapping write
      do_read(32'h0000_0200, vt[2].data, t);
      do_write(32'h0000_0200, bdat, 1'b0);
      drain();
      do_read(32'h0000_0200, bdat, t);
      drain();

      // reset during BEAT1
      beat_cyc.delete();
      do_read(32'h0000_0100, vt[0].data, t);
      step(10);
      chk("mid_rvalid", {63'h0, bmem_rvalid}, 64'h1);
      rst = 1'b1;
      step();
      sbq.delete();
      chk("rst_mid_rvalid", {63'h0, bmem_rvalid}, 64'h0);
      chk("rst_mid_ready", {63'h0, bmem_ready}, 64'h0);
      rst = 1'b0;
      #1;
      chk("rst_mid_ready1", {63'h0, bmem_ready}, 64'h1);
      step(20);
      chk("rst_mid_beats", 64'(beat_cyc.size()), 64'd2);
      do_read(32'h0000_0200, bdat, t);
      drain();

      // read alongside write is ignored; write lands
      beat_cyc.delete();
      do_write(32'h0000_01E0, cdat, 1'b1);
      step(15);
      chk("rw_no_beats", 64'(beat_cyc.size()), 64'd0);
      do_read(32'h0000_01E0, cdat, t);
      drain();

      // write dropped after two beats keeps the partial line
      bmem_addr  = 32'h0000_0040;
      bmem_write = 1'b1;
      bmem_wdata = 64'hD0D0_D0D0_0000_0000;
      step();
      bmem_wdata = 64'hD1D1_D1D1_0000_0001;
      step();
      bmem_write = 1'b0;
      step();
      pexp = {vt[4].data[255:128], 64'hD1D1_D1D1_0000_0001,
              64'hD0D0_D0D0_0000_0000};
      do_read(32'h0000_0040, pexp, t);
      drain();

      // misaligned read: error flag
      mon_en    = 1'b0;
      bmem_addr = 32'h0000_0104;
      bmem_read = 1'b1;
      wait_ready("err_ready");
      step();
      bmem_read = 1'b0;
      step(2);
      chk("err_set", {63'h0, bmem_err}, {63'h0, ERR_EXP});
      step(5);
      chk("err_sticky", {63'h0, bmem_err}, {63'h0, ERR_EXP});
      step(20);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: got no finish want finish by 2ms");
      $fatal(1, "timeout");
   end

endmodule
